// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcodes and flag bit positions shared by the ALU pipeline
package alu_pkg;

  localparam logic [3:0] OP_NOTA = 4'b0000;
  localparam logic [3:0] OP_NOTB = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_XNOR = 4'b0101;
  localparam logic [3:0] OP_SLT  = 4'b0110;
  localparam logic [3:0] OP_SGT  = 4'b0111;
  localparam logic [3:0] OP_SLL  = 4'b1000;
  localparam logic [3:0] OP_SRL  = 4'b1001;
  localparam logic [3:0] OP_SRA  = 4'b1010;
  localparam logic [3:0] OP_ADD  = 4'b1011;
  localparam logic [3:0] OP_SUB  = 4'b1100;

  // Flags are packed as {err, n, z, c, v}.
  localparam int FLAG_V   = 0;
  localparam int FLAG_C   = 1;
  localparam int FLAG_Z   = 2;
  localparam int FLAG_N   = 3;
  localparam int FLAG_ERR = 4;
  localparam int FLAGS_W  = 5;

endpackage

// File: rtl/alu_core.sv
// rtl/alu_core.sv - combinational ALU datapath producing result and {err, n, z, c, v}
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [3:0]         op,
  output logic [WIDTH-1:0]   result,
  output logic [FLAGS_W-1:0] flags
);

  logic [SHW-1:0] shamt;
  logic [WIDTH:0] sum;
  logic [WIDTH:0] diff;
  logic           carry;
  logic           ovf;
  logic           err;

  assign shamt = b[SHW-1:0];
  assign sum   = {1'b0, a} + {1'b0, b};
  // Top bit of the extended difference is the borrow, so carry is its inverse.
  assign diff  = {1'b0, a} - {1'b0, b};

  always_comb begin
    result = '0;
    carry  = 1'b0;
    ovf    = 1'b0;
    err    = 1'b0;
    case (op)
      OP_NOTA: result = ~a;
      OP_NOTB: result = ~b;
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      OP_XNOR: result = ~(a ^ b);
      OP_SLT:  result = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SGT:  result = {{(WIDTH-1){1'b0}}, ($signed(a) > $signed(b))};
      OP_SLL:  result = a << shamt;
      OP_SRL:  result = a >> shamt;
      OP_SRA:  result = $unsigned($signed(a) >>> shamt);
      OP_ADD: begin
        result = sum[WIDTH-1:0];
        carry  = sum[WIDTH];
        ovf    = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        result = diff[WIDTH-1:0];
        carry  = ~diff[WIDTH];
        ovf    = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      default: err = 1'b1;
    endcase
  end

  always_comb begin
    flags           = '0;
    flags[FLAG_ERR] = err;
    flags[FLAG_N]   = result[WIDTH-1];
    flags[FLAG_Z]   = (result == '0);
    flags[FLAG_C]   = carry;
    flags[FLAG_V]   = ovf;
  end

endmodule

// File: rtl/alu_pipe.sv
// rtl/alu_pipe.sv - two-stage ALU pipeline with valid/ready handshake on both sides
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [4:0]       flags
);

  logic                 en;
  logic                 s1_valid;
  logic [WIDTH-1:0]     s1_a;
  logic [WIDTH-1:0]     s1_b;
  logic [3:0]           s1_op;
  logic [WIDTH-1:0]     core_result;
  logic [FLAGS_W-1:0]   core_flags;

  // Whole pipe moves as one; it stalls only when a result is waiting unconsumed.
  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_op    <= '0;
    end else if (en) begin
      s1_valid <= in_valid;
      s1_a     <= a;
      s1_b     <= b;
      s1_op    <= op;
    end
  end

  alu_core #(
    .WIDTH (WIDTH),
    .SHW   (SHW)
  ) u_core (
    .a      (s1_a),
    .b      (s1_b),
    .op     (s1_op),
    .result (core_result),
    .flags  (core_flags)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      result    <= '0;
      flags     <= '0;
    end else if (en) begin
      out_valid <= s1_valid;
      result    <= core_result;
      flags     <= core_flags;
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// tb/tb_alu_pipe.sv - scoreboard bench for alu_pipe with directed and randomized traffic
module tb_alu_pipe;
  import alu_pkg::*;

  localparam int W = 32;
  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -64'sd2147483648;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [3:0]   op;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic [4:0]   flags;

  typedef struct {
    logic [W-1:0] res;
    logic [4:0]   flg;
    int           id;
  } exp_t;

  exp_t sb[$];
  int   vectors     = 0;
  int   miscompares = 0;
  int   popped      = 0;
  int   next_id     = 0;

  always #5 clk = ~clk;

  alu_pipe #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .flags     (flags)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic [W-1:0] r, input logic [4:0] f);
    exp_t e;
    e.res = r;
    e.flg = f;
    e.id  = next_id;
    next_id++;
    return e;
  endfunction

  // Reference: integer arithmetic on 64-bit values, flags derived from ranges.
  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic [3:0] o);
    longint       sx, sy, s;
    int           sh;
    logic [W-1:0] r;
    logic         c, v, err;
    sx  = longint'($signed(x));
    sy  = longint'($signed(y));
    sh  = int'(y % 32);
    r   = '0;
    c   = 1'b0;
    v   = 1'b0;
    err = 1'b0;
    case (o)
      4'd0:  r = ~x;
      4'd1:  r = ~y;
      4'd2:  r = x & y;
      4'd3:  r = x | y;
      4'd4:  r = x ^ y;
      4'd5:  r = ~(x ^ y);
      4'd6:  r = (sx < sy) ? 32'd1 : 32'd0;
      4'd7:  r = (sx > sy) ? 32'd1 : 32'd0;
      4'd8:  r = x << sh;
      4'd9:  r = x >> sh;
      4'd10: r = 32'(sx >>> sh);
      4'd11: begin
        s = longint'(x) + longint'(y);
        r = s[31:0];
        c = (s >= 64'sh1_0000_0000);
        v = (sx + sy > SMAX) || (sx + sy < SMIN);
      end
      4'd12: begin
        r = x - y;
        c = (x >= y);
        v = (sx - sy > SMAX) || (sx - sy < SMIN);
      end
      default: err = 1'b1;
    endcase
    return mk(r, {err, r[31], (r == 0), c, v});
  endfunction

  // Inputs change on the falling edge; acceptance is judged just before the rising edge.
  task automatic cycle_drive(input logic v, input logic [W-1:0] x, input logic [W-1:0] y,
                             input logic [3:0] o, input logic ordy, output logic acc);
    @(negedge clk);
    in_valid  = v;
    a         = x;
    b         = y;
    op        = o;
    out_ready = ordy;
    #4;
    acc = v && in_ready;
  endtask

  task automatic idle(input int n);
    logic acc;
    for (int i = 0; i < n; i++) cycle_drive(1'b0, '0, '0, 4'd0, 1'b1, acc);
  endtask

  task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y, input logic [3:0] o, input exp_t e);
    logic acc;
    int   n;
    n = 0;
    do begin
      cycle_drive(1'b1, x, y, o, 1'b1, acc);
      n++;
    end while (!acc && n < 20);
    if (acc) sb.push_back(e);
    else check($sformatf("issue_timeout vec%0d", e.id), 64'(acc), 64'd1);
  endtask

  task automatic latency_check(input string name, input logic [W-1:0] x, input logic [W-1:0] y,
                               input logic [3:0] o, input exp_t e);
    logic acc;
    cycle_drive(1'b1, x, y, o, 1'b1, acc);
    check({name, " accepted"}, 64'(acc), 64'd1);
    if (acc) sb.push_back(e);
    cycle_drive(1'b0, '0, '0, 4'd0, 1'b1, acc);
    check({name, " out_valid_cycle1"}, 64'(out_valid), 64'd0);
    cycle_drive(1'b0, '0, '0, 4'd0, 1'b1, acc);
    check({name, " out_valid_cycle2"}, 64'(out_valid), 64'd1);
  endtask

  function automatic logic [W-1:0] rnd_operand();
    case ($urandom_range(0, 5))
      0:       return 32'h0000_0000;
      1:       return 32'h0000_0001;
      2:       return 32'h7FFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // Monitor: retire one scoreboard entry per handshake.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #4;
      if (!reset && out_valid && out_ready) begin
        if (sb.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_output: got result 0x%0h flags 0x%0h, expected no output", result, flags);
        end else begin
          e = sb.pop_front();
          check($sformatf("vec%0d result", e.id), 64'(result), 64'(e.res));
          check($sformatf("vec%0d flags", e.id), 64'(flags), 64'(e.flg));
          popped++;
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic acc;
    logic ordy;
    int   idx;
    int   base;
    int   n;
    logic [W-1:0] x, y;
    logic [3:0]   o;

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; op = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset out_valid", 64'(out_valid), 64'd0);
    check("reset result", 64'(result), 64'd0);
    check("reset flags", 64'(flags), 64'd0);
    check("reset in_ready", 64'(in_ready), 64'd1);
    reset = 1'b0;
    #1;
    check("post_reset in_ready", 64'(in_ready), 64'd1);

    idle(2);
    latency_check("add_overflow", 32'h7FFF_FFFF, 32'h1, OP_ADD, mk(32'h8000_0000, 5'b01001));

    issue(32'h5, 32'h5, OP_SUB, mk(32'h0, 5'b00110));
    issue(32'h0, 32'h1, OP_SUB, mk(32'hFFFF_FFFF, 5'b01000));
    issue(32'h8000_0000, 32'h24, OP_SRA, mk(32'hF800_0000, 5'b01000));
    issue(32'h8000_0000, 32'h24, OP_SRL, mk(32'h0800_0000, 5'b00000));
    issue(32'h8000_0000, 32'h24, OP_SLL, mk(32'h0, 5'b00100));
    issue(32'h8000_0000, 32'h1, OP_SLT, mk(32'h1, 5'b00000));
    issue(32'h8000_0000, 32'h1, OP_SGT, mk(32'h0, 5'b00100));
    issue(32'h8000_0000, 32'h20, OP_SRA, mk(32'h8000_0000, 5'b01000));
    issue(32'h1234_5678, 32'h9ABC_DEF0, 4'b1101, mk(32'h0, 5'b10100));
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'b1110, mk(32'h0, 5'b10100));
    issue(32'h0, 32'h0, 4'b1111, mk(32'h0, 5'b10100));
    issue(32'hFFFF_FFFF, 32'h1, OP_ADD, mk(32'h0, 5'b00110));
    issue(32'h8000_0000, 32'h8000_0000, OP_ADD, mk(32'h0, 5'b00111));
    issue(32'h0F0F_0F0F, 32'h0F0F_0F0F, OP_XNOR, mk(32'hFFFF_FFFF, 5'b01000));
    idle(4);
    check("directed drained", 64'(sb.size()), 64'd0);

    // Four adds with the consumer stalled for three cycles after the first result appears.
    base = popped;
    idx  = 0;
    for (int c = 0; c < 16; c++) begin
      ordy = !(c >= 2 && c <= 4);
      if (idx < 4) cycle_drive(1'b1, 32'(idx + 1), 32'(idx + 1), OP_ADD, ordy, acc);
      else         cycle_drive(1'b0, '0, '0, 4'd0, ordy, acc);
      if (acc) begin
        sb.push_back(mk(32'(2 * (idx + 1)), 5'b00000));
        idx++;
      end
      if (c >= 2 && c <= 4) begin
        check($sformatf("stall c%0d in_ready", c), 64'(in_ready), 64'd0);
        check($sformatf("stall c%0d out_valid", c), 64'(out_valid), 64'd1);
        check($sformatf("stall c%0d result", c), 64'(result), 64'd2);
        check($sformatf("stall c%0d flags", c), 64'(flags), 64'd0);
      end
    end
    check("stall delivered", 64'(popped - base), 64'd4);
    check("stall queue empty", 64'(sb.size()), 64'd0);

    // Reset with two requests in flight.
    idle(2);
    issue(32'd10, 32'd20, OP_ADD, mk(32'd30, 5'b00000));
    issue(32'd30, 32'd40, OP_SUB, mk(32'hFFFF_FFF6, 5'b01000));
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    check("pre_reset out_valid", 64'(out_valid), 64'd1);
    reset = 1'b1;
    #1;
    check("midreset out_valid", 64'(out_valid), 64'd0);
    check("midreset result", 64'(result), 64'd0);
    check("midreset flags", 64'(flags), 64'd0);
    check("midreset in_ready", 64'(in_ready), 64'd1);
    sb.delete();
    @(negedge clk);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle_drive(1'b0, '0, '0, 4'd0, 1'b1, acc);
      check($sformatf("post_reset idle%0d out_valid", i), 64'(out_valid), 64'd0);
    end
    latency_check("after_reset", 32'd3, 32'd4, OP_ADD, mk(32'd7, 5'b00000));

    // Randomized traffic against the reference model.
    for (int i = 0; i < 400; i++) begin
      x    = rnd_operand();
      y    = rnd_operand();
      o    = 4'($urandom_range(0, 15));
      ordy = ($urandom_range(0, 3) != 0);
      cycle_drive(($urandom_range(0, 3) != 0), x, y, o, ordy, acc);
      if (acc) sb.push_back(model(x, y, o));
    end
    n = 0;
    while (sb.size() > 0 && n < 50) begin
      cycle_drive(1'b0, '0, '0, 4'd0, 1'b1, acc);
      n++;
    end
    check("random drained", 64'(sb.size()), 64'd0);
    idle(3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/alu_pipe.md
ALU_PIPE -- requirements
Module: alu_pipe

Interface
REQ-001 The module SHALL have parameter WIDTH, default 32, giving the operand/result width (legal range 8..64, power of two).
REQ-002 The module SHALL have parameter SHW, default $clog2(WIDTH), giving the shift-amount width taken from b.
REQ-003 The module SHALL have port clk  input  1  as the single clock; all state updates on its rising edge.
REQ-004 The module SHALL have port reset  input  1  as the reset: asynchronous, active-high.
REQ-005 The module SHALL have port in_valid  input  1  meaning that a, b and op carry a request.
REQ-006 The module SHALL have port in_ready  output  1  meaning that the request is accepted this cycle if in_valid=1.
REQ-007 The module SHALL have ports a, b  input  WIDTH  as the operands.
REQ-008 The module SHALL have port op  input  4  as the opcode.
REQ-009 The module SHALL have port out_valid  output  1  meaning that result and flags are valid.
REQ-010 The module SHALL have port out_ready  input  1  meaning that the consumer takes the result this cycle.
REQ-011 The module SHALL have port result  output  WIDTH  as the registered result.
REQ-012 The module SHALL have port flags  output  5  as registered {err, n, z, c, v}.

Function
REQ-013 Opcodes SHALL be: 0000 ~a; 0001 ~b; 0010 a&b; 0011 a|b; 0100 a^b; 0101 ~(a^b); 0110 signed a<b ? 1 : 0; 0111 signed a>b ? 1 : 0; 1000 a<<b[SHW-1:0]; 1001 logical a>>b[SHW-1:0]; 1010 arithmetic a>>>b[SHW-1:0]; 1011 a+b; 1100 a-b.
REQ-014 Opcodes 1101..1111 SHALL produce result 0 with err=1; all other ops give err=0.
REQ-015 n SHALL equal result[WIDTH-1], and z SHALL equal (result==0), for every op including the err ops.
REQ-016 For add, c SHALL be the carry out; for sub, c SHALL be 1 when there is no borrow (a>=b unsigned); for all other ops c SHALL be 0.
REQ-017 v SHALL be signed overflow for add/sub and 0 for all other ops.
REQ-018 Shift amounts SHALL use only the low SHW bits of b, with upper bits ignored; a shift of 0 returns a.
REQ-019 The pipeline SHALL have 2 stages: stage 1 registers a, b, op and valid; stage 2 computes and registers result, flags and valid.
REQ-020 An accepted request SHALL appear on out_valid exactly 2 cycles after acceptance when out_ready is held at 1.
REQ-021 The advance enable SHALL be en = !out_valid || out_ready, with in_ready = en (combinational); both stages advance only when en=1.
REQ-022 While en=0, result, flags, out_valid and the stage-1 contents SHALL hold unchanged, and no request is accepted or lost.
REQ-023 Results SHALL emerge in acceptance order; sustained throughput is 1 per cycle when out_ready=1.
REQ-024 A bubble (in_valid=0 while en=1) SHALL propagate as valid=0; registered data for bubbles is don't-care but SHALL NOT raise out_valid.
REQ-025 The same-cycle case of accept with out_ready=1 while out_valid=1 SHALL retire the old result and advance both stages in that cycle.

Reset
REQ-026 Reset SHALL immediately clear the stage-1 valid and out_valid to 0, and set result to 0 and flags to 0.
REQ-027 Reset asserted mid-operation SHALL discard all in-flight requests; after release, the first out_valid SHALL come only from a request accepted after release.
REQ-028 in_ready SHALL be 1 during and right after reset, since out_valid=0.

Structure
REQ-029 Opcode localparams (OP_NOTA..OP_SUB) and the flag bit indices SHALL live in shared package alu_pkg.
REQ-030 The combinational datapath SHALL be sub-module alu_core (WIDTH-parametrised: a, b, op -> result, flags), instantiated in stage 2.

Verification
REQ-031 The bench SHALL cover: WIDTH=32, op=1011, a=0x7FFFFFFF, b=0x1, out_ready=1 -> result 0x80000000, flags n=1 z=0 c=0 v=1 err=0, out_valid 2 cycles after accept.
REQ-032 The bench SHALL cover: op=1100, a=b=0x5 -> result 0, z=1 c=1 v=0; op=1100, a=0, b=1 -> 0xFFFFFFFF, n=1 c=0.
REQ-033 The bench SHALL cover: a=0x80000000, b=0x24 (shamt 4): op 1010 -> 0xF8000000; op 1001 -> 0x08000000; op 1000 -> 0x00000000 with z=1; op 0110 with a=0x80000000, b=0x1 -> 1.
REQ-034 The bench SHALL cover: op=1101, 1110 and 1111 with any operands -> result 0, err=1, z=1.
REQ-035 The bench SHALL cover: issue 4 back-to-back adds (1+1, 2+2, 3+3, 4+4) with out_ready low for 3 cycles mid-stream -> in_ready low while stalled, outputs held, then 2, 4, 6, 8 delivered in order with none dropped or duplicated.
REQ-036 The bench SHALL cover: reset pulsed while 2 requests are in flight -> out_valid=0 in the same cycle, no stale result after release, and the next accepted request completes in 2 cycles.
